fetch_decode_unit: RTL
======================

Name: fetch_decode_unit

Overview:
- Sits directly downstream of the PC controller.
- Consumes its pc/decodePulse, fetches the instruction word from instruction memory over a variable-latency request/valid handshake, and decodes it into operatorType and register/immediate fields.
- Issues one decoded instruction per fetch to the reservation-station dispatch logic.
- Returns operatorType plus a static branch prediction (jump/jumppc) to the PC controller.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- IMEM_TIMEOUT, 64, max cycles waiting for imem_valid before abort.
- ADD_OP, 6'b000001, add opcode.
- LW_OP, 6'b000010, load opcode.
- SW_OP, 6'b000100, store opcode.
- BNE_OP, 6'b001000, branch-not-equal opcode.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc  in  ADDR_W  fetch address from PC controller
- decodePulse  in  1  fetch request, sampled as a level
- pcChange  in  1  flush from commit (mispredict/redirect)
- imem_req  out  1  one-cycle memory read strobe
- imem_addr  out  ADDR_W  word address, held from request until response/abort
- imem_valid  in  1  response strobe
- imem_data  in  32  instruction word, valid with imem_valid
- issue_valid  out  1  one-cycle pulse: decoded fields valid
- operatorType  out  6  opcode bits [31:26]
- rs, rt, rd  out  5 each  bits [25:21], [20:16], [15:11]
- imm  out  32  sign-extended bits [15:0]
- inst_pc  out  ADDR_W  pc of the issued instruction
- jump  out  1  predicted taken, valid with issue_valid for BNE only
- jumppc  out  ADDR_W  predicted target
- busy  out  1  high in any state except IDLE
- illegal  out  1  one-cycle pulse on an unknown opcode
- timeout_err  out  1  sticky, cleared only by reset

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timeout counter 0; discard flag 0.
  - Reset mid-fetch abandons the request; a late imem_valid after reset is ignored.
- FSM states: IDLE, WAIT, ISSUE.
- IDLE:
  - If decodePulse=1 and pcChange=0: latch pc into imem_addr and inst_pc, pulse imem_req for 1 cycle, go to WAIT.
  - decodePulse while not IDLE is ignored; there is no queueing.
- WAIT:
  - Counter increments each cycle.
  - imem_valid=1: latch imem_data, go to ISSUE.
  - imem_valid may arrive as early as the cycle after imem_req, so minimum issue latency is decodePulse -> issue_valid = 3 cycles.
  - Counter reaching IMEM_TIMEOUT with no response: set timeout_err, set discard flag, go to IDLE.
- ISSUE:
  - Drive issue_valid=1 with all fields for exactly 1 cycle, then go to IDLE.
  - Fields hold their values until the next ISSUE.
  - Unknown opcode (not ADD/LW/SW/BNE): issue_valid=0, illegal=1, operatorType forced to 0.
- Branch prediction:
  - BNE_OP: jumppc = inst_pc + 1 + imm, modulo 2^ADDR_W.
  - jump = imm[31]: backward branch predicted taken, forward predicted not taken.
  - Non-branch opcodes: jump=0, jumppc=0.
- Flush:
  - pcChange=1 in any cycle: issue_valid forced 0 that cycle; state goes to IDLE.
  - If in WAIT, set the discard flag.
  - pcChange has priority over decodePulse and imem_valid in the same cycle.
- Discard flag: the next imem_valid is dropped and the flag is cleared. While the flag is set, a new request may be issued but its response is taken only after the stale one is dropped. Memory responses are in order.
- Simultaneous imem_valid and timeout in the same cycle: the response wins and the counter is ignored.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants ADD_OP/LW_OP/SW_OP/BNE_OP, shared with pcControl and the reservation stations.
  - FSM state encoding.
  - instruction field bit positions.
- One combinational sub-module, inst_decoder: 32-bit word in; opcode, rs/rt/rd, sign-extended imm, legal flag out.
- The FSM, handshake, flush/discard and prediction adder stay in the top.

Test Plan:
- Basic fetch:
  - Stimulus: reset, pc=5, decodePulse=1; memory returns 32'h2022_0003 (opcode 001000, rs=1, rt=2, imm=3) 1 cycle after req.
  - Response: imem_addr=5; issue_valid at cycle 3 with operatorType=001000, rs=1, rt=2, imm=3, jump=0, jumppc=9.
- Backward branch:
  - Stimulus: pc=20, BNE with imm=16'hFFFA.
  - Response: imm=32'hFFFF_FFFA, jump=1, jumppc=15.
- Flush during WAIT:
  - Stimulus: pcChange at cycle 2; stale response at cycle 4; new fetch pc=40 whose response (ADD) arrives at cycle 7.
  - Response: no issue from the stale word; ADD issued with inst_pc=40.
- Timeout:
  - Stimulus: no imem_valid for 64 cycles.
  - Response: timeout_err=1, busy=0; a late response is discarded.
- Illegal opcode:
  - Stimulus: word 32'hFC00_0000.
  - Response: illegal pulse, issue_valid=0, operatorType=0.
- Synchronous reset mid-WAIT:
  - Stimulus: reset asserted while in WAIT, then imem_valid.
  - Response: all outputs 0, busy=0, no issue.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch FSM encoding and instruction field positions.
// Used by the fetch/decode unit, the PC controller and the reservation stations.
package cpu_pkg;

    localparam logic [5:0] ADD_OP = 6'b000001;
    localparam logic [5:0] LW_OP  = 6'b000010;
    localparam logic [5:0] SW_OP  = 6'b000100;
    localparam logic [5:0] BNE_OP = 6'b001000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_t;

    function automatic logic opcode_is_legal(input logic [5:0] op);
        return (op == ADD_OP) || (op == LW_OP) || (op == SW_OP) || (op == BNE_OP);
    endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory read handshake: one-cycle request strobe, held address,
// variable-latency in-order response strobe with data.
interface fetch_decode_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [31:0]       data;

    modport master (output req, output addr, input valid, input data);
    modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/inst_decoder.sv
// Combinational instruction field extraction with sign-extended immediate
// and opcode legality check.
module inst_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        legal
);

    assign opcode = word[OPC_MSB:OPC_LSB];
    assign rs     = word[RS_MSB:RS_LSB];
    assign rt     = word[RT_MSB:RT_LSB];
    assign rd     = word[RD_MSB:RD_LSB];
    assign legal  = opcode_is_legal(opcode);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_imm
            if (gi <= IMM_MSB) begin : g_low
                assign imm[gi] = word[gi];
            end else begin : g_ext
                assign imm[gi] = word[IMM_MSB];
            end
        end
    endgenerate

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: requests the word at pc, waits for the memory response
// (with timeout and flush handling), decodes it and issues one instruction.
module fetch_decode_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int IMEM_TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                decodePulse,
    input  logic                pcChange,
    fetch_decode_unit_if.master imem,
    output logic                issue_valid,
    output logic [5:0]          operatorType,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [31:0]         imm,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic                jump,
    output logic [ADDR_W-1:0]   jumppc,
    output logic                busy,
    output logic                illegal,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(IMEM_TIMEOUT + 1);

    fetch_state_t      state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              discard_reg, discard_next;
    logic              timeout_reg, timeout_next;
    logic              req_reg, req_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
    logic              accept;

    logic [5:0]        op_reg;
    logic [4:0]        rs_reg, rt_reg, rd_reg;
    logic [31:0]       imm_reg;
    logic              jump_reg;
    logic [ADDR_W-1:0] jumppc_reg;
    logic              legal_reg;

    logic [5:0]        dec_op;
    logic [4:0]        dec_rs, dec_rt, dec_rd;
    logic [31:0]       dec_imm;
    logic              dec_legal;
    logic              dec_is_bne;
    logic [ADDR_W-1:0] branch_target;

    inst_decoder u_dec (
        .word   (imem.data),
        .opcode (dec_op),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .rd     (dec_rd),
        .imm    (dec_imm),
        .legal  (dec_legal)
    );

    assign dec_is_bne    = dec_legal && (dec_op == BNE_OP);
    assign branch_target = inst_pc_reg + ADDR_W'(1) + ADDR_W'($signed(dec_imm));

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        discard_next = discard_reg;
        timeout_next = timeout_reg;
        req_next     = 1'b0;
        addr_next    = addr_reg;
        inst_pc_next = inst_pc_reg;
        accept       = 1'b0;

        // A response arriving while the flag is set is the stale one being dropped.
        if (imem.valid && discard_reg) begin
            discard_next = 1'b0;
        end

        if (pcChange) begin
            state_next = ST_IDLE;
            // Our own response consumed this very cycle leaves nothing outstanding.
            if (state_reg == ST_WAIT && !(imem.valid && !discard_reg)) begin
                discard_next = 1'b1;
            end
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (decodePulse) begin
                        req_next     = 1'b1;
                        addr_next    = pc;
                        inst_pc_next = pc;
                        count_next   = '0;
                        state_next   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    count_next = count_reg + CNT_W'(1);
                    if (imem.valid && !discard_reg) begin
                        accept     = 1'b1;
                        state_next = ST_ISSUE;
                    end else if (count_next == CNT_W'(IMEM_TIMEOUT)) begin
                        timeout_next = 1'b1;
                        discard_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            discard_reg <= 1'b0;
            timeout_reg <= 1'b0;
            req_reg     <= 1'b0;
            addr_reg    <= '0;
            inst_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            discard_reg <= discard_next;
            timeout_reg <= timeout_next;
            req_reg     <= req_next;
            addr_reg    <= addr_next;
            inst_pc_reg <= inst_pc_next;
        end
    end

    // Decoded fields are captured with the response and held until the next one.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg     <= '0;
            rs_reg     <= '0;
            rt_reg     <= '0;
            rd_reg     <= '0;
            imm_reg    <= '0;
            jump_reg   <= 1'b0;
            jumppc_reg <= '0;
            legal_reg  <= 1'b0;
        end else if (accept) begin
            op_reg     <= dec_legal ? dec_op : 6'd0;
            rs_reg     <= dec_rs;
            rt_reg     <= dec_rt;
            rd_reg     <= dec_rd;
            imm_reg    <= dec_imm;
            jump_reg   <= dec_is_bne && dec_imm[31];
            jumppc_reg <= dec_is_bne ? branch_target : '0;
            legal_reg  <= dec_legal;
        end
    end

    assign imem.req     = req_reg;
    assign imem.addr    = addr_reg;
    assign issue_valid  = (state_reg == ST_ISSUE) && legal_reg && !pcChange;
    assign illegal      = (state_reg == ST_ISSUE) && !legal_reg && !pcChange;
    assign operatorType = op_reg;
    assign rs           = rs_reg;
    assign rt           = rt_reg;
    assign rd           = rd_reg;
    assign imm          = imm_reg;
    assign inst_pc      = inst_pc_reg;
    assign jump         = jump_reg;
    assign jumppc       = jumppc_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign timeout_err  = timeout_reg;

endmodule
